bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- CPU-side bus initiator: accepts byte/word load-store requests from the core over a valid/ready port and runs them on the SoC memory bus.
- SoC bus: address/data, read/write strobes, bus_wait; the responder lowers bus_wait one cycle after it sees a strobe.
- Splits 16-bit accesses into two little-endian byte transactions and returns read data plus completion on a single-cycle response pulse.
- Sits between the CPU execution core and the SoC bus responder.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles a strobe is held with bus_wait high before abort (used only with the optional feature; valid range 1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  high when a request can be accepted (state IDLE)
- req_write  in  1  1 = write, 0 = read
- req_word  in  1  1 = 16-bit access (addr, addr+1), 0 = byte
- req_addr  in  16  access address
- req_wdata  in  16  write data; low byte used for byte writes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data; byte reads zero-extended
- rsp_error  out  1  valid with rsp_valid; 1 = access aborted by timeout
- busy  out  1  high when state is not IDLE
- bus_address_out  out  16  bus address
- bus_data_out  out  8  bus write data
- bus_data_in  in  8  bus read data, valid while bus_wait is low
- bus_read  out  1  read strobe
- bus_write  out  1  write strobe
- bus_wait  in  1  responder not done; low = current strobe completed

Behaviour:
- Reset values: bus_read=0, bus_write=0, bus_address_out=0, bus_data_out=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE.
- Reset mid-transaction aborts the access immediately, with no response.
- All outputs are registered. req_ready = (state==IDLE); busy = !req_ready.
- States: IDLE, ACCESS, RELEASE. Internal byte index bi (0/1).
- IDLE:
  - Accept on edge with req_valid & req_ready.
  - Latch write, word, addr, wdata; bi=0.
  - Drive bus_address_out=addr, bus_data_out=wdata[7:0], and the matching strobe; go to ACCESS.
- ACCESS: hold address, data and strobe stable while bus_wait=1. On an edge with bus_wait=0:
  - for a read, capture bus_data_in into byte lane bi;
  - drop the strobe and go to RELEASE.
- RELEASE:
  - Wait for bus_wait=1, so a stale completion is never reused for the next strobe.
  - Then, if word && bi==0: bi=1, address=addr+1 (16-bit wrap, 0xFFFF -> 0x0000), data=wdata[15:8], reassert strobe, go to ACCESS.
  - Otherwise: pulse rsp_valid for one cycle and go to IDLE.
- Responses:
  - Byte read: rsp_rdata={8'h00, byte}.
  - Word read: rsp_rdata={byte1, byte0}.
  - Write: rsp_rdata unchanged.
  - rsp_error=0 unless timeout.
- Never assert bus_read and bus_write together. No new request is accepted during the cycle rsp_valid is high; req_ready rises the same cycle.
- Latency with a zero-wait responder (wait falls one cycle after the strobe and rises one cycle after it drops): rsp_valid is high in the cycle after the 4th clock edge following acceptance for a byte, after the 8th for a word.
- Back-to-back: the next accept can occur on the edge after the rsp_valid cycle begins.

Optional Feature:
- Macro BUS_MASTER_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on each strobe assertion and increments each ACCESS cycle with bus_wait=1.
  - At TIMEOUT_CYCLES: drop the strobe, skip any remaining byte, go to RELEASE, then pulse rsp_valid with rsp_error=1 and rsp_rdata=0x0000.
- Undefined: no counter; ACCESS waits indefinitely; rsp_error is tied 0.

Test Plan:
- Byte read addr 0x0001, responder returns 0x55 with zero wait -> bus_read high 1 cycle after accept, address 0x0001; rsp_valid after 4 edges; rsp_rdata=0x0055; rsp_error=0.
- Word read addr 0xFFFF, bytes 0x12 @0xFFFF, 0x34 @0x0000 -> two read strobes, second address 0x0000; rsp_rdata=0x3412 after 8 edges.
- Word write 0xBEEF to 0x2000, responder with 3 wait cycles -> write 0xEF @0x2000 then 0xBE @0x2001; strobe stable during waits; single rsp_valid; bus_read never high.
- Responder holds bus_wait low through the drop -> RELEASE holds until wait=1; next strobe only after wait returns high.
- rst_n low during ACCESS of a word read -> next edge: strobes 0, state IDLE, req_ready=1, no rsp_valid.
- Timeout: BUS_MASTER_TIMEOUT_EN set, TIMEOUT_CYCLES=4, bus_wait stuck high -> strobe dropped after 4 wait cycles; rsp_valid with rsp_error=1, rsp_rdata=0.

Source files
------------

// File: rtl/bus_master_if.sv
// bus_master_if -- CPU-side initiator for the 8-bit SoC memory bus.
//
// Takes byte/word load-store requests from the core over a valid/ready port.
// Each request runs as one bus transaction, or as two when it is a 16-bit access.
// A 16-bit access is split into two little-endian byte transactions at addr and
// addr+1. The address wraps at 16 bits.
// Completion comes back as a single-cycle rsp_valid pulse. On a read the pulse
// carries the read data.
//
// Optional feature: define BUS_MASTER_TIMEOUT_EN to abort a strobe that has been
// held with bus_wait high for TIMEOUT_CYCLES cycles. An aborted access returns
// rsp_error=1 with rsp_rdata=0. Without the macro ACCESS waits indefinitely and
// rsp_error is tied low.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   req_valid/ready   core request handshake (ready == state IDLE)
//   req_write         1 = store, 0 = load
//   req_word          1 = 16-bit access, 0 = byte
//   req_addr/wdata    access address / store data (low byte for byte stores)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         load data (byte loads zero-extended; unchanged on stores)
//   rsp_error         timeout abort flag, qualified by rsp_valid
//   busy              state != IDLE
//   bus_address_out   bus address
//   bus_data_out      bus write data
//   bus_data_in       bus read data, valid while bus_wait is low
//   bus_read/write    bus strobes, never high together
//   bus_wait          responder busy; low = current strobe completed
module bus_master_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [15:0] bus_address_out,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        bus_read,
    output logic        bus_write,
    input  logic        bus_wait
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t      state;
    logic        lat_write;
    logic        lat_word;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        bi;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic        aborted;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;
    logic       timed_out;
    logic       rsp_error_r;

    assign aborted   = timed_out;
    assign rsp_error = rsp_error_r;
`else
    assign aborted   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            bus_read        <= 1'b0;
            bus_write       <= 1'b0;
            bus_address_out <= '0;
            bus_data_out    <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            bi              <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            to_cnt          <= '0;
            timed_out       <= 1'b0;
            rsp_error_r     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write       <= req_write;
                        lat_word        <= req_word;
                        lat_addr        <= req_addr;
                        lat_wdata       <= req_wdata;
                        bi              <= 1'b0;
                        bus_address_out <= req_addr;
                        bus_data_out    <= req_wdata[7:0];
                        bus_read        <= !req_write;
                        bus_write       <= req_write;
                        req_ready       <= 1'b0;
                        busy            <= 1'b1;
                        state           <= ACCESS;
`ifdef BUS_MASTER_TIMEOUT_EN
                        to_cnt          <= '0;
                        timed_out       <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    if (!bus_wait) begin
                        if (!lat_write) begin
                            if (bi) byte1 <= bus_data_in;
                            else    byte0 <= bus_data_in;
                        end
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        state     <= RELEASE;
                    end
`ifdef BUS_MASTER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        // Give up on this strobe; RELEASE reports the abort.
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                RELEASE: begin
                    // Only move on once the responder has raised bus_wait again.
                    // Otherwise the next strobe could see the old completion.
                    if (bus_wait) begin
                        if (lat_word && !bi && !aborted) begin
                            bi              <= 1'b1;
                            bus_address_out <= lat_addr + 16'd1;
                            bus_data_out    <= lat_wdata[15:8];
                            bus_read        <= !lat_write;
                            bus_write       <= lat_write;
                            state           <= ACCESS;
`ifdef BUS_MASTER_TIMEOUT_EN
                            to_cnt          <= '0;
`endif
                        end else begin
                            rsp_valid <= 1'b1;
                            if (aborted)
                                rsp_rdata <= 16'h0000;
                            else if (!lat_write)
                                rsp_rdata <= lat_word ? {byte1, byte0} : {8'h00, byte0};
`ifdef BUS_MASTER_TIMEOUT_EN
                            rsp_error_r <= timed_out;
`endif
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if.
// A behavioural bus responder has a programmable wait count and a programmable
// hold-low time after each strobe is dropped. It can also keep bus_wait stuck
// high.
// Each request pushes its expected response and its expected bus operations
// into queues. The queues are popped when the DUT produces them.
module tb_bus_master_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_word;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error, busy;
    logic [15:0] rsp_rdata, bus_address_out;
    logic [7:0]  bus_data_out, bus_data_in;
    logic        bus_read, bus_write;
    logic        bus_wait = 1'b1;

    always #5 clk = ~clk;

    bus_master_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .busy(busy), .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
        .bus_data_in(bus_data_in), .bus_read(bus_read), .bus_write(bus_write),
        .bus_wait(bus_wait)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    rsp_t        rsp_q[$];
    op_t         op_q[$];
    logic [7:0]  bus_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] last_rdata = 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    int waits_cfg = 0;
    int hold_low_cfg = 0;
    bit stuck = 1'b0;
    int wcnt = 0;
    int hcnt = 0;
    int viol_rw = 0;
    int viol_stable = 0;
    int viol_early = 0;

    assign bus_data_in = bus_mem[bus_address_out];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: checks each completed strobe against the expected operation
    always @(posedge clk) begin : responder
        op_t o;
        if (rst_n && (bus_read || bus_write) && !bus_wait) begin
            if (op_q.size() == 0) begin
                check("unexpected_bus_op", 32'd1, 32'd0);
            end else begin
                o = op_q.pop_front();
                check("op_kind", {31'd0, bus_write}, {31'd0, o.wr});
                check("op_addr", {16'd0, bus_address_out}, {16'd0, o.addr});
                if (o.wr) check("op_wdata", {24'd0, bus_data_out}, {24'd0, o.data});
            end
            if (bus_write) bus_mem[bus_address_out] <= bus_data_out;
        end
        if (stuck) begin
            bus_wait <= 1'b1;
        end else if (bus_read || bus_write) begin
            hcnt = 0;
            if (wcnt < waits_cfg) begin
                wcnt++;
                bus_wait <= 1'b1;
            end else begin
                bus_wait <= 1'b0;
            end
        end else begin
            wcnt = 0;
            if (!bus_wait && hcnt < hold_low_cfg) begin
                hcnt++;
                bus_wait <= 1'b0;
            end else begin
                bus_wait <= 1'b1;
            end
        end
    end

    // Monitor: response scoreboard plus bus protocol observations
    logic        prev_strobe = 1'b0;
    logic        prev_wait   = 1'b1;
    logic [25:0] prev_bus    = '0;

    always @(negedge clk) begin : monitor
        rsp_t e;
        logic strobe;
        logic [25:0] cur_bus;
        strobe  = bus_read | bus_write;
        cur_bus = {bus_read, bus_write, bus_address_out, bus_data_out};
        if (bus_read && bus_write) viol_rw++;
        if (strobe && prev_strobe && prev_wait && cur_bus != prev_bus) viol_stable++;
        if (strobe && !prev_strobe && !prev_wait) viol_early++;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
                if (e.lat >= 0) check("rsp_latency", cyc - accept_cyc, e.lat);
            end
        end
        prev_strobe = strobe;
        prev_wait   = bus_wait;
        prev_bus    = cur_bus;
    end

    // mode 0: normal, 1: aborted by reset (nothing expected), 2: timeout
    task automatic issue(input bit wr, input bit wd, input logic [15:0] a,
                         input logic [15:0] wdat, input int lat, input int mode,
                         input bit sync);
        rsp_t e;
        op_t  o;
        logic [15:0] a1;
        int n;
        a1 = a + 16'd1;
        if (mode == 0) begin
            o.wr = wr; o.addr = a; o.data = wdat[7:0];
            op_q.push_back(o);
            if (wd) begin
                o.addr = a1; o.data = wdat[15:8];
                op_q.push_back(o);
            end
            if (wr) begin
                ref_mem[a] = wdat[7:0];
                if (wd) ref_mem[a1] = wdat[15:8];
                e.rdata = last_rdata;
            end else begin
                e.rdata = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
            end
            e.err = 1'b0; e.lat = lat;
            rsp_q.push_back(e);
            last_rdata = e.rdata;
        end else if (mode == 2) begin
            e.rdata = 16'h0000; e.err = 1'b1; e.lat = lat;
            rsp_q.push_back(e);
            last_rdata = 16'h0000;
        end
        if (sync) @(negedge clk);
        req_write = wr; req_word = wd; req_addr = a; req_wdata = wdat;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || op_q.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", rsp_q.size() + op_q.size(), 0);
        rsp_q.delete();
        op_q.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] ra, rd;
        bit rw, rwd;
        int rwait, n;
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus_read", {31'd0, bus_read}, 32'd0);
        check("rst_bus_write", {31'd0, bus_write}, 32'd0);
        check("rst_addr", {16'd0, bus_address_out}, 32'd0);
        check("rst_wdata", {24'd0, bus_data_out}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        rst_n = 1'b1;

        // Byte read, zero-wait responder
        bus_mem[16'h0001] = 8'h55; ref_mem[16'h0001] = 8'h55;
        issue(1'b0, 1'b0, 16'h0001, 16'h0000, 4, 0, 1'b1);
        check("t1_bus_read", {31'd0, bus_read}, 32'd1);
        check("t1_bus_write", {31'd0, bus_write}, 32'd0);
        check("t1_addr", {16'd0, bus_address_out}, 32'h0001);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_req_ready", {31'd0, req_ready}, 32'd0);
        wait_done();

        // Word read across the address wrap
        bus_mem[16'hFFFF] = 8'h12; ref_mem[16'hFFFF] = 8'h12;
        bus_mem[16'h0000] = 8'h34; ref_mem[16'h0000] = 8'h34;
        issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 8, 0, 1'b1);
        wait_done();

        // Word write with 3 wait cycles; rsp_rdata keeps 0x3412
        waits_cfg = 3;
        issue(1'b1, 1'b1, 16'h2000, 16'hBEEF, 14, 0, 1'b1);
        wait_done();
        check("t3_mem_lo", {24'd0, bus_mem[16'h2000]}, 32'hEF);
        check("t3_mem_hi", {24'd0, bus_mem[16'h2001]}, 32'hBE);
        waits_cfg = 0;

        // Responder keeps bus_wait low after the strobe drops
        hold_low_cfg = 3;
        issue(1'b0, 1'b1, 16'h0100, 16'h0000, -1, 0, 1'b1);
        wait_done();
        hold_low_cfg = 0;
        check("t4_early_strobe", viol_early, 0);

        // Back-to-back: new request offered during the rsp_valid cycle
        issue(1'b0, 1'b0, 16'h0001, 16'h0000, 4, 0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 1'b0, 16'h0002, 16'h0000, 4, 0, 1'b0);
        check("b2b_bus_read", {31'd0, bus_read}, 32'd1);
        check("b2b_addr", {16'd0, bus_address_out}, 32'h0002);
        wait_done();

        // Reset during ACCESS of a word read
        waits_cfg = 3;
        issue(1'b0, 1'b1, 16'h3000, 16'h0000, -1, 1, 1'b1);
        @(negedge clk);
        check("t6_in_access", {31'd0, bus_read}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_bus_read", {31'd0, bus_read}, 32'd0);
        check("t6_bus_write", {31'd0, bus_write}, 32'd0);
        check("t6_req_ready", {31'd0, req_ready}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        waits_cfg = 0;
        repeat (10) @(negedge clk);
        issue(1'b0, 1'b0, 16'h3000, 16'h0000, 4, 0, 1'b1);
        wait_done();

`ifdef BUS_MASTER_TIMEOUT_EN
        // bus_wait stuck high: strobe dropped after 4 wait cycles
        stuck = 1'b1;
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 5, 2, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("to_strobe", {31'd0, bus_read}, (k < 4) ? 32'd1 : 32'd0);
        end
        wait_done();
        stuck = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // Random mix; latency follows from the responder wait count
        for (int t = 0; t < 16; t++) begin
            rwait = $urandom_range(0, 2);
            waits_cfg = rwait;
            rw  = 1'($urandom_range(0, 1));
            rwd = 1'($urandom_range(0, 1));
            ra  = 16'($urandom_range(0, 65535));
            rd  = 16'($urandom_range(0, 65535));
            if (t == 15) ra = 16'hFFFF;
            issue(rw, rwd, ra, rd, (4 + rwait) * (rwd ? 2 : 1), 0, 1'b1);
            wait_done();
        end
        waits_cfg = 0;

        check("rw_overlap", viol_rw, 0);
        check("strobe_stable", viol_stable, 0);
        check("early_strobe", viol_early, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
